// File: rtl/led_wb_slave_pkg.sv
// Shared types and constants for the LED bank Wishbone slave and its
// serial shifter. Optional feature macro: LED_WB_SLAVE_WRITE_MERGE_EN.
package led_wb_slave_pkg;

    localparam int SHIFT_BITS = 16;
    localparam int BIT_W      = $clog2(SHIFT_BITS);

    localparam logic BANK0 = 1'b0;
    localparam logic BANK1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        BIT_LO,
        BIT_HI,
        LATCH
    } sr_state_e;

    typedef enum logic [1:0] {
        RSP_NONE,
        RSP_ACK,
        RSP_ERR,
        RSP_RTY
    } wb_rsp_e;

    // Highest selected byte lane wins; lane 3 has top priority.
    function automatic logic [7:0] lane_byte(input logic [3:0] sel, input logic [31:0] dat);
        logic [7:0] b;
        if (sel[3])      b = dat[31:24];
        else if (sel[2]) b = dat[23:16];
        else if (sel[1]) b = dat[15:8];
        else             b = dat[7:0];
        return b;
    endfunction

endpackage

// File: rtl/led_wb_slave_ledsr_shifter.sv
// Serialises a 16-bit snapshot MSB first onto a 74HC595-style chain,
// then pulses the storage latch. Each sr_clk phase and the latch pulse
// last CLK_DIV cycles. Optional feature macro: LED_WB_SLAVE_WRITE_MERGE_EN
// (a start while busy is remembered and replayed right after the latch).
module ledsr_shifter
    import led_wb_slave_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                  wb_clk,
    input  logic                  wb_rst,
    input  logic                  start,
    input  logic [SHIFT_BITS-1:0] data,
    output logic                  busy,
    output logic                  sr_clk,
    output logic                  sr_dat,
    output logic                  sr_latch
);

    localparam int                PH_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_FIRST = BIT_W'(SHIFT_BITS - 1);

    sr_state_e                state_q, state_d;
    logic [PH_W-1:0]          phase_q;
    logic [BIT_W-1:0]         bit_cnt_q;
    logic [SHIFT_BITS-1:0]    snap_q;
    logic                     phase_end;
    logic                     restart;
    logic                     load;

    assign phase_end = (phase_q == PH_LAST);

`ifdef LED_WB_SLAVE_WRITE_MERGE_EN
    logic pending_q;
    // A start arriving on the final latch cycle is folded into the restart.
    assign restart = pending_q | start;
`else
    assign restart = 1'b0;
`endif

    // Snapshot is captured on a fresh start and on a merged restart.
    assign load = ((state_q == IDLE) && start) ||
                  ((state_q == LATCH) && phase_end && restart);

    // State register.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (start)     state_d = BIT_LO;
            BIT_LO: if (phase_end) state_d = BIT_HI;
            BIT_HI: if (phase_end) state_d = (bit_cnt_q == '0) ? LATCH : BIT_LO;
            LATCH:  if (phase_end) state_d = restart ? BIT_LO : IDLE;
            default:               state_d = IDLE;
        endcase
    end

    // Phase timer, bit counter and snapshot register.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            phase_q   <= '0;
            bit_cnt_q <= '0;
            snap_q    <= '0;
        end else begin
            if (state_q == IDLE || phase_end) phase_q <= '0;
            else                              phase_q <= phase_q + PH_W'(1);

            if (load) begin
                bit_cnt_q <= BIT_FIRST;
                snap_q    <= data;
            end else if (state_q == BIT_HI && phase_end && bit_cnt_q != '0) begin
                bit_cnt_q <= bit_cnt_q - BIT_W'(1);
            end
        end
    end

`ifdef LED_WB_SLAVE_WRITE_MERGE_EN
    // Remember writes that landed mid-shift until the next snapshot load.
    always_ff @(posedge wb_clk) begin
        if (wb_rst)                    pending_q <= 1'b0;
        else if (load)                 pending_q <= 1'b0;
        else if (start && busy)        pending_q <= 1'b1;
    end
`endif

    // Output decode from the current state.
    always_comb begin
        busy     = (state_q != IDLE);
        sr_clk   = (state_q == BIT_HI);
        sr_latch = (state_q == LATCH);
        sr_dat   = 1'b0;
        if (state_q == BIT_LO || state_q == BIT_HI) sr_dat = snap_q[bit_cnt_q];
    end

endmodule

// File: rtl/led_wb_slave.sv
// Wishbone classic slave with two 8-bit LED banks at BASE_ADR and
// BASE_ADR+1. Every accepted write kicks off a serial update of the
// external shift-register chain. Optional feature macro:
// LED_WB_SLAVE_WRITE_MERGE_EN (writes while busy are acked and merged
// into one follow-up shift instead of being retried).
module led_wb_slave
    import led_wb_slave_pkg::*;
#(
    parameter logic [31:0] BASE_ADR = 32'h9100_0000,
    parameter int          CLK_DIV  = 4
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic [2:0]  wb_cti_i,
    input  logic [1:0]  wb_bte_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_rty_o,
    output logic        sr_clk,
    output logic        sr_dat,
    output logic        sr_latch,
    output logic        busy_o
);

    wb_rsp_e     rsp_q, rsp_d;
    logic [7:0]  bank0_q, bank1_q;
    logic [31:0] dat_q;
    logic        start_q;
    logic        req, hit, bank_sel, wr_en;
    logic [7:0]  rd_byte;
    logic        busy;

    // Classic-only slave: burst hints carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{wb_cti_i, wb_bte_i};

    // A new request is only taken while no response is on the bus.
    assign req      = wb_cyc_i & wb_stb_i & ~(wb_ack_o | wb_err_o | wb_rty_o);
    assign hit      = (wb_adr_i[31:1] == BASE_ADR[31:1]);
    assign bank_sel = wb_adr_i[0];
    assign rd_byte  = (bank_sel == BANK1) ? bank1_q : bank0_q;

    // Decide the single response for this request and whether it writes.
    always_comb begin
        rsp_d = RSP_NONE;
        wr_en = 1'b0;
        if (req) begin
            if (!hit)                      rsp_d = RSP_ERR;
            else if (!wb_we_i)             rsp_d = RSP_ACK;
            else if (wb_sel_i == 4'b0000)  rsp_d = RSP_ERR;
`ifdef LED_WB_SLAVE_WRITE_MERGE_EN
            else begin
                rsp_d = RSP_ACK;
                wr_en = 1'b1;
            end
`else
            else if (busy)                 rsp_d = RSP_RTY;
            else begin
                rsp_d = RSP_ACK;
                wr_en = 1'b1;
            end
`endif
        end
    end

    // Registered response, read data, bank writes and shift kick.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            rsp_q   <= RSP_NONE;
            dat_q   <= '0;
            start_q <= 1'b0;
            bank0_q <= '0;
            bank1_q <= '0;
        end else begin
            rsp_q   <= rsp_d;
            start_q <= wr_en;
            dat_q   <= (req && hit && !wb_we_i) ? {4{rd_byte}} : 32'h0;
            if (wr_en) begin
                if (bank_sel == BANK1) bank1_q <= lane_byte(wb_sel_i, wb_dat_i);
                else                   bank0_q <= lane_byte(wb_sel_i, wb_dat_i);
            end
        end
    end

    assign wb_ack_o = (rsp_q == RSP_ACK);
    assign wb_err_o = (rsp_q == RSP_ERR);
`ifdef LED_WB_SLAVE_WRITE_MERGE_EN
    assign wb_rty_o = 1'b0;
`else
    assign wb_rty_o = (rsp_q == RSP_RTY);
`endif
    assign wb_dat_o = dat_q;
    assign busy_o   = busy;

    ledsr_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .wb_clk   (wb_clk),
        .wb_rst   (wb_rst),
        .start    (start_q),
        .data     ({bank1_q, bank0_q}),
        .busy     (busy),
        .sr_clk   (sr_clk),
        .sr_dat   (sr_dat),
        .sr_latch (sr_latch)
    );

endmodule

// File: tb/tb_led_wb_slave.sv
// Directed bench for led_wb_slave with CLK_DIV=2. Bus responses and
// shifted words are predicted into queues when stimulus is driven and
// popped when the DUT produces them.
module tb_led_wb_slave;

    localparam logic [2:0] R_ACK = 3'b001;
    localparam logic [2:0] R_ERR = 3'b010;
    localparam logic [2:0] R_RTY = 3'b100;

    logic        wb_clk = 1'b0;
    logic        wb_rst;
    logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i, wb_cyc_i, wb_stb_i;
    logic [2:0]  wb_cti_i;
    logic [1:0]  wb_bte_i;
    logic        wb_ack_o, wb_err_o, wb_rty_o;
    logic        sr_clk, sr_dat, sr_latch, busy_o;

    int tests = 0;
    int fails = 0;

    logic [34:0] rsp_q[$];
    logic [15:0] sh_q[$];
    logic [7:0]  b0 = 8'h00, b1 = 8'h00;

    // monitor state
    logic        prev_clk = 1'b0, prev_latch = 1'b0;
    logic [15:0] mon_word = '0;
    int          mon_nbits = 0;
    int          busy_cnt = 0, last_busy = 0;
    int          latch_cnt = 0, last_latch = 0;

    led_wb_slave #(
        .BASE_ADR (32'h9100_0000),
        .CLK_DIV  (2)
    ) dut (
        .wb_clk   (wb_clk),
        .wb_rst   (wb_rst),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_sel_i (wb_sel_i),
        .wb_we_i  (wb_we_i),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_cti_i (wb_cti_i),
        .wb_bte_i (wb_bte_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o),
        .wb_err_o (wb_err_o),
        .wb_rty_o (wb_rty_o),
        .sr_clk   (sr_clk),
        .sr_dat   (sr_dat),
        .sr_latch (sr_latch),
        .busy_o   (busy_o)
    );

    always #5 wb_clk = ~wb_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Caller is at a negedge. One request, response checked one cycle later,
    // then the bus must be quiet again the cycle after.
    task automatic xfer(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic we,
                        input logic [2:0] ersp, input logic [31:0] edat);
        logic [34:0] e;
        rsp_q.push_back({ersp, edat});
        wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel; wb_we_i = we;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        @(negedge wb_clk);
        e = rsp_q.pop_front();
        chk({tag, "_rsp"}, {29'b0, wb_rty_o, wb_err_o, wb_ack_o, wb_dat_o}, {29'b0, e});
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        @(negedge wb_clk);
        chk({tag, "_quiet"}, {29'b0, wb_rty_o, wb_err_o, wb_ack_o, wb_dat_o}, 64'h0);
    endtask

    task automatic wait_idle(input string tag, input int bound, input int exp_busy);
        int n = 0;
        while (busy_o && n < bound) begin
            @(negedge wb_clk);
            n++;
        end
        chk({tag, "_idle"}, {63'b0, busy_o}, 64'h0);
        @(negedge wb_clk);
        chk({tag, "_busylen"}, 64'(last_busy), 64'(exp_busy));
        chk({tag, "_latchlen"}, 64'(last_latch), 64'd2);
        chk({tag, "_shq_empty"}, 64'(sh_q.size()), 64'd0);
    endtask

    // Reassemble the serial stream on sr_clk rising edges; judge it on latch.
    always @(negedge wb_clk) begin
        if (wb_rst) begin
            mon_nbits = 0; mon_word = '0;
            busy_cnt = 0; latch_cnt = 0;
        end else begin
            if (sr_clk && !prev_clk) begin
                mon_word = {mon_word[14:0], sr_dat};
                mon_nbits++;
            end
            if (sr_latch && !prev_latch) begin
                chk("shift_nbits", 64'(mon_nbits), 64'd16);
                if (sh_q.size() == 0) begin
                    chk("shift_unexpected", 64'(mon_word), 64'h1_0000);
                end else begin
                    chk("shift_word", 64'(mon_word), 64'(sh_q.pop_front()));
                end
                mon_nbits = 0; mon_word = '0;
            end
            if (busy_o) busy_cnt++;
            else if (busy_cnt != 0) begin last_busy = busy_cnt; busy_cnt = 0; end
            if (sr_latch) latch_cnt++;
            else if (latch_cnt != 0) begin last_latch = latch_cnt; latch_cnt = 0; end
        end
        prev_clk   = sr_clk;
        prev_latch = sr_latch;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        wb_rst = 1'b1;
        wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0; wb_we_i = 1'b0;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_cti_i = '0; wb_bte_i = '0;
        repeat (3) @(negedge wb_clk);
        chk("reset_outs", {26'b0, wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o,
                           sr_clk, sr_dat, sr_latch, busy_o}, 64'h0);
        wb_rst = 1'b0;
        @(negedge wb_clk);

        // Bank 0 write from the top lane
        b0 = 8'hA5; sh_q.push_back({b1, b0});
        xfer("wr_b0_a5", 32'h9100_0000, 32'hA500_0000, 4'b1000, 1'b1, R_ACK, 32'h0);
        chk("busy_started", {63'b0, busy_o}, 64'h1);
        repeat (8) @(negedge wb_clk);
`ifndef LED_WB_SLAVE_WRITE_MERGE_EN
        xfer("wr_busy_rty", 32'h9100_0001, 32'h003C_0000, 4'b0100, 1'b1, R_RTY, 32'h0);
        xfer("rd_b1_unch", 32'h9100_0001, 32'h0, 4'b1111, 1'b0, R_ACK, 32'h0);
`endif
        xfer("rd_b0_busy", 32'h9100_0000, 32'h0, 4'b1111, 1'b0, R_ACK, 32'hA5A5_A5A5);
        wait_idle("shift1", 200, 66);

        // Retry after busy falls
        b1 = 8'h3C; sh_q.push_back({b1, b0});
        xfer("wr_b1_3c", 32'h9100_0001, 32'h003C_0000, 4'b0100, 1'b1, R_ACK, 32'h0);
        xfer("rd_b1_busy", 32'h9100_0001, 32'h0, 4'b0001, 1'b0, R_ACK, 32'h3C3C_3C3C);
        wait_idle("shift2", 200, 66);

        // Error paths start nothing
        xfer("wr_miss", 32'h9100_0004, 32'hFFFF_FFFF, 4'b1111, 1'b1, R_ERR, 32'h0);
        xfer("wr_sel0", 32'h9100_0000, 32'hFFFF_FFFF, 4'b0000, 1'b1, R_ERR, 32'h0);
        xfer("rd_miss", 32'h9100_0002, 32'h0, 4'b1111, 1'b0, R_ERR, 32'h0);
        repeat (4) @(negedge wb_clk);
        chk("no_shift_after_err", {63'b0, busy_o}, 64'h0);
        xfer("rd_b0_after_err", 32'h9100_0000, 32'h0, 4'b1111, 1'b0, R_ACK, 32'hA5A5_A5A5);

        // Lower lane priority
        b0 = 8'h5A; sh_q.push_back({b1, b0});
        xfer("wr_lane1", 32'h9100_0000, 32'h0000_5A77, 4'b0011, 1'b1, R_ACK, 32'h0);
        wait_idle("shift3", 200, 66);
        b1 = 8'hC3; sh_q.push_back({b1, b0});
        xfer("wr_lane0", 32'h9100_0001, 32'h1111_11C3, 4'b0001, 1'b1, R_ACK, 32'h0);
        wait_idle("shift4", 200, 66);
        xfer("rd_b0_lane", 32'h9100_0000, 32'h0, 4'b1111, 1'b0, R_ACK, 32'h5A5A_5A5A);

`ifdef LED_WB_SLAVE_WRITE_MERGE_EN
        // Two writes mid-shift merge into one follow-up shift
        b0 = 8'h11; sh_q.push_back({b1, b0});
        xfer("mg_wr0", 32'h9100_0000, 32'h1100_0000, 4'b1000, 1'b1, R_ACK, 32'h0);
        repeat (8) @(negedge wb_clk);
        b1 = 8'h22;
        xfer("mg_wr1", 32'h9100_0001, 32'h0022_0000, 4'b0100, 1'b1, R_ACK, 32'h0);
        b0 = 8'h33; sh_q.push_back({b1, b0});
        xfer("mg_wr2", 32'h9100_0000, 32'h3300_0000, 4'b1000, 1'b1, R_ACK, 32'h0);
        wait_idle("merge", 400, 132);
`endif

        // Reset in the high phase of bit 7
        xfer("wr_pre_rst", 32'h9100_0000, 32'h8100_0000, 4'b1000, 1'b1, R_ACK, 32'h0);
        n = 0;
        while (!(mon_nbits == 9 && sr_clk) && n < 300) begin
            @(negedge wb_clk);
            n++;
        end
        chk("bit7_reached", {62'b0, (mon_nbits == 9), sr_clk}, 64'h3);
        wb_rst = 1'b1;
        @(negedge wb_clk);
        chk("midrst_outs", {26'b0, wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o,
                            sr_clk, sr_dat, sr_latch, busy_o}, 64'h0);
        wb_rst = 1'b0;
        b0 = 8'h00; b1 = 8'h00;
        sh_q.delete();
        @(negedge wb_clk);
        xfer("rd_b0_rst", 32'h9100_0000, 32'h0, 4'b1111, 1'b0, R_ACK, 32'h0);
        xfer("rd_b1_rst", 32'h9100_0001, 32'h0, 4'b1111, 1'b0, R_ACK, 32'h0);
        repeat (3) @(negedge wb_clk);
        chk("no_shift_after_rst", {62'b0, busy_o, sr_latch}, 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
